// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one core request into one or two aligned word
// transfers, with byte-lane strobes, shifted store data and merged load data.
module lsu_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_load_data,
  output logic        resp_misaligned,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_address,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  bus_wstrobe,
  output logic [31:0] bus_wdata
);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond, StResp} state_e;

  state_e      state_q, state_d;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] lo_q;
  logic [31:0] load_q;
  logic        fault_q;

  logic        accept;
  logic        lo_en;
  logic        load_en;
  logic        req_split;
  logic        split;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [63:0] merged;
  logic [31:0] raw;
  logic [31:0] ext;

  // Access size in bytes: 1, 2 or 4.
  function automatic logic [2:0] size_of(input logic [1:0] f);
    unique case (f)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // Lane geometry of the latched request and of the incoming one.
  always_comb begin
    off       = addr_q[1:0];
    size      = size_of(funct3_q[1:0]);
    split     = (({1'b0, off} + size) > 3'd4);
    req_split = (({1'b0, req_address[1:0]} + size_of(req_funct3[1:0])) > 3'd4);
    mask8     = ((8'd1 << size) - 8'd1) << off;
    data64    = {32'd0, sdata_q} << {off, 3'b000};
  end

  // Load merge: the second beat supplies the upper word; shift down and extend.
  always_comb begin
    merged = (state_q == StSecond) ? {bus_rdata, lo_q} : {32'd0, bus_rdata};
    raw    = 32'(merged >> {off, 3'b000});
    unique case (funct3_q[1:0])
      2'b00:   ext = funct3_q[2] ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = funct3_q[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // Next-state and bus/handshake outputs.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    bus_valid   = 1'b0;
    bus_address = 32'd0;
    bus_wstrobe = 4'd0;
    bus_wdata   = 32'd0;
    accept      = 1'b0;
    lo_en       = 1'b0;
    load_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_split && !ALLOW_MISALIGNED) ? StResp : StFirst;
        end
      end
      StFirst: begin
        bus_valid   = 1'b1;
        bus_address = {addr_q[31:2], 2'b00};
        bus_wstrobe = store_q ? mask8[3:0] : 4'd0;
        bus_wdata   = data64[31:0];
        if (bus_ready) begin
          if (split) begin
            lo_en   = 1'b1;
            state_d = StSecond;
          end else begin
            load_en = 1'b1;
            state_d = StResp;
          end
        end
      end
      StSecond: begin
        bus_valid   = 1'b1;
        bus_address = {addr_q[31:2], 2'b00} + 32'd4;
        bus_wstrobe = store_q ? mask8[7:4] : 4'd0;
        bus_wdata   = data64[63:32];
        if (bus_ready) begin
          load_en = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign resp_load_data  = load_q;
  assign resp_misaligned = (state_q == StResp) && fault_q;

  // State, latched request and load result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      sdata_q  <= 32'd0;
      lo_q     <= 32'd0;
      load_q   <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_address;
        sdata_q  <= req_store_data;
        fault_q  <= req_split && !ALLOW_MISALIGNED;
        if (req_split && !ALLOW_MISALIGNED) begin
          load_q <= 32'd0;
        end
      end
      if (lo_en) begin
        lo_q <= bus_rdata;
      end
      // Stores leave the previous load result in place.
      if (load_en && !store_q) begin
        load_q <= ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: one splitting instance and one faulting one.
module tb_lsu_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid, req_valid_nm;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_store_data;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  logic        req_ready, resp_valid, resp_misaligned, bus_valid;
  logic [31:0] resp_load_data, bus_address, bus_wdata;
  logic [3:0]  bus_wstrobe;

  logic        nm_req_ready, nm_resp_valid, nm_resp_misaligned, nm_bus_valid;
  logic [31:0] nm_resp_load_data, nm_bus_address, nm_bus_wdata;
  logic [3:0]  nm_bus_wstrobe;

  // Simple bus: one special address returns rd_val1, everything else rd_val0.
  logic [31:0] rd_addr1, rd_val0, rd_val1;
  assign bus_rdata = (bus_address == rd_addr1) ? rd_val1 : rd_val0;

  int checks = 0;
  int errors = 0;

  lsu_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_load_data(resp_load_data),
    .resp_misaligned(resp_misaligned),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_address(bus_address),
    .bus_rdata(bus_rdata), .bus_wstrobe(bus_wstrobe), .bus_wdata(bus_wdata)
  );

  lsu_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_nm), .req_ready(nm_req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
    .resp_valid(nm_resp_valid), .resp_load_data(nm_resp_load_data),
    .resp_misaligned(nm_resp_misaligned),
    .bus_valid(nm_bus_valid), .bus_ready(bus_ready), .bus_address(nm_bus_address),
    .bus_rdata(bus_rdata), .bus_wstrobe(nm_bus_wstrobe), .bus_wdata(nm_bus_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accept edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic to_nm);
    @(posedge clk);
    #1;
    req_store      = st;
    req_funct3     = f3;
    req_address    = addr;
    req_store_data = data;
    if (to_nm) req_valid_nm = 1'b1;
    else       req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_valid_nm = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_valid_nm = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_store_data = 32'd0; bus_ready = 1'b1;
    rd_addr1 = 32'hDEAD_0000; rd_val0 = 32'd0; rd_val1 = 32'd0;

    // Reset state
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_misaligned", 32'(resp_misaligned), 32'd0);
    check("rst_load_data", resp_load_data, 32'd0);
    check("rst_bus_address", bus_address, 32'd0);
    check("rst_wstrobe", 32'(bus_wstrobe), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // LW 0x100
    rd_val0 = 32'h1122_3344;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b0);
    @(negedge clk);
    check("lw_c1_bus_valid", 32'(bus_valid), 32'd1);
    check("lw_c1_addr", bus_address, 32'h0000_0100);
    check("lw_c1_wstrobe", 32'(bus_wstrobe), 32'd0);
    check("lw_c1_resp_valid", 32'(resp_valid), 32'd0);
    check("lw_c1_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("lw_c2_resp_valid", 32'(resp_valid), 32'd1);
    check("lw_c2_bus_valid", 32'(bus_valid), 32'd0);
    check("lw_c2_req_ready", 32'(req_ready), 32'd0);
    check("lw_c2_data", resp_load_data, 32'h1122_3344);
    check("lw_c2_misaligned", 32'(resp_misaligned), 32'd0);
    @(negedge clk);
    check("lw_c3_resp_valid", 32'(resp_valid), 32'd0);
    check("lw_c3_req_ready", 32'(req_ready), 32'd1);
    check("lw_c3_data_held", resp_load_data, 32'h1122_3344);

    // LB / LBU 0x103, byte 0x80
    rd_val0 = 32'h8011_2233;
    issue(1'b0, 3'b000, 32'h0000_0103, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("lb_resp_valid", 32'(resp_valid), 32'd1);
    check("lb_data", resp_load_data, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("lbu_data", resp_load_data, 32'h0000_0080);

    // SB 0x203 data 0xAB
    issue(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 1'b0);
    @(negedge clk);
    check("sb_addr", bus_address, 32'h0000_0200);
    check("sb_wstrobe", 32'(bus_wstrobe), 32'b1000);
    check("sb_wdata_top", 32'(bus_wdata[31:24]), 32'hAB);
    @(negedge clk);
    check("sb_resp_valid", 32'(resp_valid), 32'd1);
    check("sb_load_data_kept", resp_load_data, 32'h0000_0080);

    // LH / LHU 0x13 split
    rd_val0 = 32'hF000_0000; rd_addr1 = 32'h0000_0014; rd_val1 = 32'h0000_0080;
    issue(1'b0, 3'b001, 32'h0000_0013, 32'd0, 1'b0);
    @(negedge clk);
    check("lh_c1_addr", bus_address, 32'h0000_0010);
    check("lh_c1_wstrobe", 32'(bus_wstrobe), 32'd0);
    @(negedge clk);
    check("lh_c2_bus_valid", 32'(bus_valid), 32'd1);
    check("lh_c2_addr", bus_address, 32'h0000_0014);
    check("lh_c2_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("lh_c3_resp_valid", 32'(resp_valid), 32'd1);
    check("lh_data", resp_load_data, 32'hFFFF_80F0);
    issue(1'b0, 3'b101, 32'h0000_0013, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("lhu_resp_valid", 32'(resp_valid), 32'd1);
    check("lhu_data", resp_load_data, 32'h0000_80F0);
    rd_addr1 = 32'hDEAD_0000;

    // SW 0xFFFFFFFE wraps
    issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 1'b0);
    @(negedge clk);
    check("sw_c1_addr", bus_address, 32'hFFFF_FFFC);
    check("sw_c1_wstrobe", 32'(bus_wstrobe), 32'b1100);
    check("sw_c1_wdata_hi", 32'(bus_wdata[31:16]), 32'h3344);
    @(negedge clk);
    check("sw_c2_addr", bus_address, 32'h0000_0000);
    check("sw_c2_wstrobe", 32'(bus_wstrobe), 32'b0011);
    check("sw_c2_wdata_lo", 32'(bus_wdata[15:0]), 32'h1122);
    @(negedge clk);
    check("sw_c3_resp_valid", 32'(resp_valid), 32'd1);

    // SH 0x40 with bus stalled three cycles
    bus_ready = 1'b0;
    issue(1'b1, 3'b001, 32'h0000_0040, 32'h0000_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sh_stall_bus_valid", 32'(bus_valid), 32'd1);
      check("sh_stall_addr", bus_address, 32'h0000_0040);
      check("sh_stall_wstrobe", 32'(bus_wstrobe), 32'b0011);
      check("sh_stall_wdata", bus_wdata, 32'h0000_BEEF);
      check("sh_stall_req_ready", 32'(req_ready), 32'd0);
      check("sh_stall_resp_valid", 32'(resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    bus_ready = 1'b1;
    @(negedge clk);
    check("sh_ready_bus_valid", 32'(bus_valid), 32'd1);
    check("sh_ready_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("sh_resp_valid", 32'(resp_valid), 32'd1);
    check("sh_resp_bus_valid", 32'(bus_valid), 32'd0);

    // Faulting instance: misaligned LW, then an aligned LW
    issue(1'b0, 3'b010, 32'h0000_0101, 32'd0, 1'b1);
    @(negedge clk);
    check("nm_fault_bus_valid", 32'(nm_bus_valid), 32'd0);
    check("nm_fault_resp_valid", 32'(nm_resp_valid), 32'd1);
    check("nm_fault_misaligned", 32'(nm_resp_misaligned), 32'd1);
    check("nm_fault_data", nm_resp_load_data, 32'd0);
    @(negedge clk);
    check("nm_fault_after", 32'(nm_resp_valid), 32'd0);
    rd_val0 = 32'hCAFE_0123;
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b1);
    @(negedge clk);
    check("nm_lw_bus_valid", 32'(nm_bus_valid), 32'd1);
    @(negedge clk);
    check("nm_lw_resp_valid", 32'(nm_resp_valid), 32'd1);
    check("nm_lw_misaligned", 32'(nm_resp_misaligned), 32'd0);
    check("nm_lw_data", nm_resp_load_data, 32'hCAFE_0123);

    // Reset during the second transfer
    issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_second_valid", 32'(bus_valid), 32'd1);
    check("rstmid_second_addr", bus_address, 32'h0000_0000);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_bus_valid", 32'(bus_valid), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_after_resp", 32'(resp_valid), 32'd0);
    check("rstmid_after_ready", 32'(req_ready), 32'd1);
    check("rstmid_after_bus", 32'(bus_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
